// File: rtl/signal_sweeper_pkg.sv
// Shared grid constants, neighbour direction encoding and sweep state for the signal sweeper.
package signal_sweeper_pkg;

  localparam int SIGNAL_bits = 16;
  localparam int GRID_W      = 64;
  localparam int GRID_H      = 48;

  localparam logic [3:0] LAST_SLOT = 4'd9;

  typedef enum logic [2:0] {
    DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
  } dir_e;

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_WRITE, ST_DONE} state_e;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } offs_t;

  // North is y-1; x grows eastwards.
  function automatic offs_t dir_offset(dir_e d);
    offs_t o;
    o.dx = 2'sd0;
    o.dy = 2'sd0;
    case (d)
      DIR_N:  o.dy = -2'sd1;
      DIR_NE: begin o.dx =  2'sd1; o.dy = -2'sd1; end
      DIR_E:  o.dx =  2'sd1;
      DIR_SE: begin o.dx =  2'sd1; o.dy =  2'sd1; end
      DIR_S:  o.dy =  2'sd1;
      DIR_SW: begin o.dx = -2'sd1; o.dy =  2'sd1; end
      DIR_W:  o.dx = -2'sd1;
      DIR_NW: begin o.dx = -2'sd1; o.dy = -2'sd1; end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/signal_window_addr.sv
// Combinational window address generator: slot 0 is the centre, slots 1..8 are d0..d7.
module signal_window_addr
  import signal_sweeper_pkg::*;
#(
  parameter int GW = 64,
  parameter int GH = 48,
  parameter int XW = 6,
  parameter int YW = 6,
  parameter int AW = 13
) (
  input  logic [XW-1:0] x_i,
  input  logic [YW-1:0] y_i,
  input  logic [3:0]    slot_i,
  input  logic          bank_i,
  output logic [AW-1:0] addr_o,
  output logic          in_bounds_o
);

  offs_t off;
  int    nx, ny;

  always_comb begin
    off = '0;
    if (slot_i != 4'd0 && slot_i <= 4'd8) off = dir_offset(dir_e'(3'(slot_i - 4'd1)));
    nx          = int'(x_i) + int'($signed(off.dx));
    ny          = int'(y_i) + int'($signed(off.dy));
    in_bounds_o = (nx >= 0) && (nx < GW) && (ny >= 0) && (ny < GH);
    addr_o      = AW'(int'(bank_i) * GW * GH + ny * GW + nx);
  end

endmodule

// File: rtl/signal_sweeper.sv
// Walks writeLoc over the grid, gathers each 3x3 window from the read bank and writes new_signal
// to the other bank. Optional saturation counter: define SIGNAL_SWEEP_SAT_COUNT_EN.
module signal_sweeper
  import signal_sweeper_pkg::*;
#(
  parameter  int GRID_W    = signal_sweeper_pkg::GRID_W,
  parameter  int GRID_H    = signal_sweeper_pkg::GRID_H,
  parameter  int ADDR_bits = $clog2(2*GRID_W*GRID_H),
  localparam int XW        = $clog2(GRID_W),
  localparam int YW        = $clog2(GRID_H),
  localparam int SCW       = $clog2(GRID_W*GRID_H+1)
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             read_bank,
  output logic                             rd_en,
  output logic [ADDR_bits-1:0]             rd_addr,
  input  logic [SIGNAL_bits-1:0]           rd_data,
  output logic                             wr_en,
  output logic [ADDR_bits-1:0]             wr_addr,
  output logic [SIGNAL_bits-1:0]           wr_data,
  output logic [XW-1:0]                    loc_x,
  output logic [YW-1:0]                    loc_y,
  output logic                             window_valid,
  output logic [SIGNAL_bits-1:0]           cur_signal,
  output logic [7:0][SIGNAL_bits-1:0]      surrounding_signals,
  input  logic [SIGNAL_bits-1:0]           new_signal
`ifdef SIGNAL_SWEEP_SAT_COUNT_EN
  ,output logic [SCW-1:0]                  sat_count
`endif
);

  localparam logic [XW-1:0] X_LAST = XW'(GRID_W-1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_H-1);

  state_e                        state_q, state_d;
  logic [3:0]                    slot_q, slot_d;
  logic [XW-1:0]                 x_q, x_d;
  logic [YW-1:0]                 y_q, y_d;
  logic                          bank_q, bank_d;
  logic                          rd_inb, inb_q;
  logic [SIGNAL_bits-1:0]        cur_stg_q, cur_q, nbr_val;
  logic [6:0][SIGNAL_bits-1:0]   nbr_stg_q;
  logic [7:0][SIGNAL_bits-1:0]   nbr_q;

  signal_window_addr #(
    .GW(GRID_W), .GH(GRID_H), .XW(XW), .YW(YW), .AW(ADDR_bits)
  ) u_rd_addr (
    .x_i(x_q), .y_i(y_q), .slot_i(slot_q), .bank_i(bank_q),
    .addr_o(rd_addr), .in_bounds_o(rd_inb)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      bank_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    x_d          = x_q;
    y_d          = y_q;
    bank_d       = bank_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    window_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_FETCH;
        slot_d  = '0;
        x_d     = '0;
        y_d     = '0;
      end
      ST_FETCH: begin
        rd_en = (slot_q <= 4'd8) && rd_inb;
        if (slot_q == LAST_SLOT) begin
          state_d = ST_WRITE;
          slot_d  = '0;
        end else begin
          slot_d = slot_q + 4'd1;
        end
      end
      ST_WRITE: begin
        wr_en        = 1'b1;
        window_valid = 1'b1;
        state_d      = ST_FETCH;
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = ST_DONE;
          end else begin
            y_d = y_q + YW'(1);
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      ST_DONE: begin
        bank_d  = ~bank_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Border neighbours reuse the centre, which is always captured first (slot 1).
  assign nbr_val = inb_q ? rd_data : cur_stg_q;

  // Window is staged during FETCH and published at slot 9 so outputs only move entering WRITE.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      inb_q     <= 1'b0;
      cur_stg_q <= '0;
      nbr_stg_q <= '0;
      cur_q     <= '0;
      nbr_q     <= '0;
    end else if (state_q == ST_FETCH) begin
      inb_q <= rd_inb;
      if (slot_q == 4'd1) begin
        cur_stg_q <= rd_data;
      end else if (slot_q >= 4'd2 && slot_q <= 4'd8) begin
        nbr_stg_q[3'(slot_q - 4'd2)] <= nbr_val;
      end else if (slot_q == LAST_SLOT) begin
        cur_q <= cur_stg_q;
        nbr_q <= {nbr_val, nbr_stg_q};
      end
    end
  end

  assign wr_addr             = ADDR_bits'((bank_q ? 0 : GRID_W*GRID_H) + int'(y_q)*GRID_W + int'(x_q));
  assign wr_data             = new_signal;
  assign busy                = (state_q != ST_IDLE);
  assign done                = (state_q == ST_DONE);
  assign read_bank           = bank_q;
  assign loc_x               = x_q;
  assign loc_y               = y_q;
  assign cur_signal          = cur_q;
  assign surrounding_signals = nbr_q;

`ifdef SIGNAL_SWEEP_SAT_COUNT_EN
  logic [SCW-1:0] sat_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sat_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      sat_q <= '0;
    end else if (state_q == ST_WRITE && new_signal == {SIGNAL_bits{1'b1}}) begin
      sat_q <= sat_q + SCW'(1);
    end
  end

  assign sat_count = sat_q;
`endif

endmodule

// File: tb/tb_signal_sweeper.sv
// Scoreboard bench for signal_sweeper on a 4x4 grid with a double-banked memory model.
module tb_signal_sweeper;

  logic              Clk, Reset_n, start;
  logic              busy, done, read_bank, rd_en, wr_en, window_valid;
  logic [4:0]        rd_addr, wr_addr;
  logic [15:0]       rd_data, wr_data, cur_signal, new_signal;
  logic [1:0]        loc_x, loc_y;
  logic [7:0][15:0]  surrounding_signals;
`ifdef SIGNAL_SWEEP_SAT_COUNT_EN
  logic [4:0]        sat_count;
`endif

  signal_sweeper #(.GRID_W(4), .GRID_H(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .done(done),
    .read_bank(read_bank), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .loc_x(loc_x), .loc_y(loc_y),
    .window_valid(window_valid), .cur_signal(cur_signal),
    .surrounding_signals(surrounding_signals), .new_signal(new_signal)
`ifdef SIGNAL_SWEEP_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory model: registered read (1-cycle latency), plus a bench load port.
  logic [15:0] mem [0:31];
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [15:0] ld_data;
  always @(posedge Clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  bit         sat_on;
  logic [3:0] cell_idx;
  assign cell_idx   = {loc_y, loc_x};
  assign new_signal = (sat_on && (cell_idx == 4'd2 || cell_idx == 4'd7 || cell_idx == 4'd11))
                      ? 16'hFFFF : cur_signal + 16'd1;

  typedef struct packed {
    logic [1:0]       x;
    logic [1:0]       y;
    logic [4:0]       addr;
    logic [15:0]      data;
    logic [15:0]      cur;
    logic [7:0][15:0] nbr;
  } exp_t;

  exp_t             exp_q[$];
  logic [15:0]      sh [0:31];
  int               DX [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int               DY [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int               n_cmp, n_err;
  logic [15:0]      w00c, w33c;
  logic [7:0][15:0] w00n, w33n;

  // Reference: expected window/write for every cell of a sweep reading bank rb.
  task automatic push_sweep(input int rb);
    exp_t e;
    int   nx, ny, c;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 4; x++) begin
        c     = y*4 + x;
        e.x   = 2'(x);
        e.y   = 2'(y);
        e.cur = sh[rb*16 + c];
        for (int d = 0; d < 8; d++) begin
          nx = x + DX[d];
          ny = y + DY[d];
          e.nbr[d] = (nx >= 0 && nx < 4 && ny >= 0 && ny < 4) ? sh[rb*16 + ny*4 + nx] : e.cur;
        end
        e.data = (sat_on && (c == 2 || c == 7 || c == 11)) ? 16'hFFFF : e.cur + 16'd1;
        e.addr = 5'((1 - rb)*16 + c);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_sweep(input int mid_at, output int cyc, output int rd00, output int wr_b1,
                           output int ovl);
    exp_t e;
    bit   fin;
    @(negedge Clk) start = 1'b1;
    cyc = 0; rd00 = 0; wr_b1 = 0; ovl = 0; fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge Clk);
      start = (n == mid_at);
      if (busy) cyc++;
      if (rd_en && loc_x == 2'd0 && loc_y == 2'd0) rd00++;
      if (rd_en && wr_en) ovl++;
      if (wr_en) begin
        if (wr_addr[4]) wr_b1++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %0h, required no write", wr_addr);
        end else begin
          e = exp_q.pop_front();
          sh[e.addr] = e.data;
          if ({window_valid, loc_x, loc_y, wr_addr, wr_data} !== {1'b1, e.x, e.y, e.addr, e.data}) begin
            n_err++;
            $display("FAIL write_cell: got %0h, required %0h",
                     {window_valid, loc_x, loc_y, wr_addr, wr_data}, {1'b1, e.x, e.y, e.addr, e.data});
          end
          n_cmp++;
          if ({cur_signal, surrounding_signals} !== {e.cur, e.nbr}) begin
            n_err++;
            $display("FAIL window(%0d,%0d): got %0h, required %0h", e.x, e.y,
                     {cur_signal, surrounding_signals}, {e.cur, e.nbr});
          end
          if (loc_x == 2'd0 && loc_y == 2'd0) begin w00c = cur_signal; w00n = surrounding_signals; end
          if (loc_x == 2'd3 && loc_y == 2'd3) begin w33c = cur_signal; w33n = surrounding_signals; end
        end
      end
      if (done) fin = 1'b1;
    end
    start = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_err++;
      $display("FAIL sweep_timeout: got no done, required done within 400 cycles");
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; start = 1'b0; ld_en = 1'b0; sat_on = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({busy, done, read_bank, rd_en, wr_en, window_valid} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b, required 000000", {busy, done, read_bank, rd_en, wr_en, window_valid});
    end
    n_cmp++;
    if ({loc_x, loc_y} !== 4'h0) begin
      n_err++;
      $display("FAIL reset_loc: got %0h, required 0", {loc_x, loc_y});
    end
    n_cmp++;
    if ({cur_signal, surrounding_signals} !== 144'h0) begin
      n_err++;
      $display("FAIL reset_window: got %0h, required 0", {cur_signal, surrounding_signals});
    end
`ifdef SIGNAL_SWEEP_SAT_COUNT_EN
    n_cmp++;
    if (sat_count !== 5'd0) begin
      n_err++;
      $display("FAIL reset_sat: got %0d, required 0", sat_count);
    end
`endif
    @(negedge Clk) Reset_n = 1'b1;
  endtask

  task automatic test_first_sweep;
    int cyc, rd00, wr_b1, ovl;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      ld_en = 1'b1; ld_addr = 5'(i); ld_data = 16'(16*i);
      sh[i] = 16'(16*i);
    end
    @(negedge Clk) ld_en = 1'b0;
    push_sweep(0);
    run_sweep(-1, cyc, rd00, wr_b1, ovl);
    @(negedge Clk);
    n_cmp++;
    if (cyc !== 177) begin n_err++; $display("FAIL sweep1_cycles: got %0d, required 177", cyc); end
    n_cmp++;
    if (wr_b1 !== 16) begin n_err++; $display("FAIL sweep1_bank1_writes: got %0d, required 16", wr_b1); end
    n_cmp++;
    if ({read_bank, busy} !== 2'b10) begin
      n_err++; $display("FAIL sweep1_bank_after: got %b, required 10", {read_bank, busy});
    end
    n_cmp++;
    if (rd00 !== 4) begin n_err++; $display("FAIL cell00_reads: got %0d, required 4", rd00); end
    n_cmp++;
    if (ovl !== 0) begin n_err++; $display("FAIL rd_wr_overlap: got %0d, required 0", ovl); end
    n_cmp++;
    if ({w00c, w00n} !== {16'd0, 16'd0, 16'd0, 16'd0, 16'd64, 16'd80, 16'd16, 16'd0, 16'd0}) begin
      n_err++; $display("FAIL cell00_window: got %0h", {w00c, w00n});
    end
    n_cmp++;
    if ({w33c, w33n} !== {16'd240, 16'd160, 16'd224, 16'd240, 16'd240, 16'd240, 16'd240, 16'd240, 16'd176}) begin
      n_err++; $display("FAIL cell33_window: got %0h", {w33c, w33n});
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem[16+i] !== 16'(16*i + 1)) begin
        n_err++; $display("FAIL bank1_cell%0d: got %0d, required %0d", i, mem[16+i], 16*i + 1);
      end
    end
  endtask

  task automatic test_second_sweep;
    int cyc, rd00, wr_b1, ovl;
    push_sweep(1);
    run_sweep(-1, cyc, rd00, wr_b1, ovl);
    @(negedge Clk);
    n_cmp++;
    if ({cyc, wr_b1, 1'b0} !== {32'd177, 32'd0, read_bank}) begin
      n_err++; $display("FAIL sweep2: got cyc %0d b1wr %0d bank %0d, required 177 0 0", cyc, wr_b1, read_bank);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (mem[i] !== 16'(16*i + 2)) begin
        n_err++; $display("FAIL bank0_cell%0d: got %0d, required %0d", i, mem[i], 16*i + 2);
      end
    end
  endtask

  task automatic test_mid_start;
    int cyc, rd00, wr_b1, ovl;
    sat_on = 1'b1;
    push_sweep(0);
    run_sweep(60, cyc, rd00, wr_b1, ovl);
    sat_on = 1'b0;
    n_cmp++;
    if (cyc !== 177) begin n_err++; $display("FAIL mid_start_cycles: got %0d, required 177", cyc); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL mid_start_left: got %0d, required 0", exp_q.size()); end
`ifdef SIGNAL_SWEEP_SAT_COUNT_EN
    repeat (2) @(negedge Clk);
    n_cmp++;
    if (sat_count !== 5'd3) begin n_err++; $display("FAIL sat_count: got %0d, required 3", sat_count); end
`endif
    @(negedge Clk);
  endtask

  task automatic test_reset_abort;
    exp_t e;
    bit   hit;
    int   nwr, cyc, rd00, wr_b1, ovl;
    push_sweep(1);
    @(negedge Clk) start = 1'b1;
    @(negedge Clk) start = 1'b0;
    hit = 1'b0; nwr = 0;
    for (int n = 0; n < 200 && !hit; n++) begin
      if (wr_en && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        sh[e.addr] = e.data;
        nwr++;
      end
      if (loc_x == 2'd1 && loc_y == 2'd1 && rd_en) hit = 1'b1;
      else @(negedge Clk);
    end
    n_cmp++;
    if ({hit, nwr} !== {1'b1, 32'd5}) begin
      n_err++; $display("FAIL abort_reach_cell5: got hit %0d writes %0d, required 1 5", hit, nwr);
    end
    #1 Reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({wr_en, busy, read_bank, loc_x, loc_y} !== 7'b0) begin
      n_err++; $display("FAIL abort_state: got %b, required 0000000", {wr_en, busy, read_bank, loc_x, loc_y});
    end
    exp_q.delete();
    @(negedge Clk) Reset_n = 1'b1;
    @(negedge Clk);
    push_sweep(0);
    run_sweep(-1, cyc, rd00, wr_b1, ovl);
    @(negedge Clk);
    n_cmp++;
    if ({cyc, wr_b1, rd00} !== {32'd177, 32'd16, 32'd4}) begin
      n_err++; $display("FAIL after_abort: got cyc %0d b1wr %0d rd00 %0d, required 177 16 4", cyc, wr_b1, rd00);
    end
    n_cmp++;
    if (read_bank !== 1'b1) begin n_err++; $display("FAIL after_abort_bank: got %0d, required 1", read_bank); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    test_reset();
    test_first_sweep();
    test_second_sweep();
    test_mid_start();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
